// File: rtl/grid_check_pkg.sv
// Shared sizing, types and enums for the grid checker.
// Purely declarative; no logic, no latency.
// No handshake here; the consumers define flow control.
package grid_check_pkg;

    localparam int ORDER  = 3;
    localparam int LENGTH = ORDER * ORDER;
    localparam int AREA   = LENGTH * LENGTH;
    localparam int ADDR_W = $clog2(AREA);
    localparam int IDX_W  = $clog2(LENGTH);
    localparam int BLK_W  = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam int CNT_W  = $clog2(AREA + 1);

    typedef logic [LENGTH-1:0] value_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ENCODING = 3'd1,
        ERR_ROW      = 3'd2,
        ERR_COL      = 3'd3,
        ERR_BLOCK    = 3'd4
    } err_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

endpackage

// File: rtl/grid_checker_if.sv
// Bundle between the grid checker and its environment (start, grid read port, result).
// Latency: wires only; read data returns one cycle after rd_en (owned by grid storage).
// Backpressure: none; the read port is a fixed-latency strobe, results are held levels.
// Ports: start (req scan), rd_en/rd_addr/rd_data (grid read), busy/done/pass/err_kind/
//        err_row/err_col (result), err_count only when GRID_CHECK_ERRCOUNT_EN is defined.
interface grid_checker_if;
    import grid_check_pkg::*;

    logic             start;
    logic             rd_en;
    logic [ADDR_W-1:0] rd_addr;
    value_t           rd_data;
    logic             busy;
    logic             done;
    logic             pass;
    logic [2:0]       err_kind;
    logic [IDX_W-1:0] err_row;
    logic [IDX_W-1:0] err_col;
`ifdef GRID_CHECK_ERRCOUNT_EN
    logic [CNT_W-1:0] err_count;

    modport master (
        input  start, rd_data,
        output rd_en, rd_addr, busy, done, pass, err_kind, err_row, err_col, err_count
    );
    modport slave (
        output start, rd_data,
        input  rd_en, rd_addr, busy, done, pass, err_kind, err_row, err_col, err_count
    );
`else
    modport master (
        input  start, rd_data,
        output rd_en, rd_addr, busy, done, pass, err_kind, err_row, err_col
    );
    modport slave (
        output start, rd_data,
        input  rd_en, rd_addr, busy, done, pass, err_kind, err_row, err_col
    );
`endif

endinterface

// File: rtl/grid_checker_onehot.sv
// One-hot detector for a single grid cell value.
// Latency: combinational.
// Backpressure: none.
// Ports: i_value (cell value), o_is_onehot (exactly one bit set).
module cell_onehot_check
    import grid_check_pkg::*;
(
    input  value_t i_value,
    output logic   o_is_onehot
);

    // Clearing the lowest set bit leaves zero only when a single bit was set.
    assign o_is_onehot = (i_value != '0) && ((i_value & (i_value - value_t'(1))) == '0);

endmodule

// File: rtl/grid_checker.sv
// Scans a finished grid row-major and checks one-hot encoding plus row/column/block uniqueness.
// Latency: reads in cycles 1..AREA after start, cell k checked in cycle k+2, done at AREA+2
//          (or one cycle after the first failing check when early stop is active).
// Backpressure: none; start is only accepted in IDLE/REPORT, ignored while busy.
// Ports: i_clock, i_reset (sync, active-high), bus (grid_checker_if.master).
// Build option: GRID_CHECK_ERRCOUNT_EN -> full scan always, err_count of failing cells.
module grid_checker
    import grid_check_pkg::*;
(
    input  logic           i_clock,
    input  logic           i_reset,
    grid_checker_if.master bus
);

`ifdef GRID_CHECK_ERRCOUNT_EN
    localparam bit STOP_ON_ERR = 1'b0;
`else
    localparam bit STOP_ON_ERR = 1'b1;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(AREA - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LENGTH - 1);
    localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(ORDER - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_chk_vld;     // a read was issued last cycle, rd_data holds a cell

    // Position of the cell currently on rd_data, kept as counters (no division).
    logic [IDX_W-1:0]  r_chk_row;
    logic [IDX_W-1:0]  r_chk_col;
    logic [BLK_W-1:0]  r_chk_rib;     // row inside the block band
    logic [BLK_W-1:0]  r_chk_cib;     // column inside the block
    logic [BLK_W-1:0]  r_chk_bc;      // block column

    value_t            r_row_seen;
    value_t            r_col_seen [LENGTH];
    value_t            r_blk_seen [ORDER];

    logic              r_err_found;
    err_kind_e         r_first_kind;
    logic [IDX_W-1:0]  r_first_row;
    logic [IDX_W-1:0]  r_first_col;

    logic              r_pass;
    err_kind_e         r_err_kind;
    logic [IDX_W-1:0]  r_err_row;
    logic [IDX_W-1:0]  r_err_col;
`ifdef GRID_CHECK_ERRCOUNT_EN
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_err_count;
`endif

    logic              w_onehot;
    logic              w_chk;
    logic              w_accept;
    logic              w_finish;
    logic              w_rd_en;
    logic              w_busy;
    logic              w_done;
    logic              w_blk_clr;
    value_t            w_row_eff;
    value_t            w_blk_eff;
    value_t            w_add;
    err_kind_e         w_cell_kind;
    logic              w_cell_err;
    logic              w_fin_err;
    err_kind_e         w_fin_kind;
    logic [IDX_W-1:0]  w_fin_row;
    logic [IDX_W-1:0]  w_fin_col;

    cell_onehot_check u_onehot (
        .i_value     (bus.rd_data),
        .o_is_onehot (w_onehot)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.start) w_state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (STOP_ON_ERR && w_cell_err)  w_state_nxt = ST_REPORT;
                else if (r_rd_addr == LAST_ADDR) w_state_nxt = ST_DRAIN;
            end
            // Fixed one-cycle read latency: the last cell is always checked in DRAIN.
            ST_DRAIN:  w_state_nxt = ST_REPORT;
            ST_REPORT: w_state_nxt = bus.start ? ST_SCAN : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_rd_en = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_SCAN:   begin w_rd_en = 1'b1; w_busy = 1'b1; end
            ST_DRAIN:  w_busy = 1'b1;
            ST_REPORT: w_done = 1'b1;
            default:   ;
        endcase
    end

    assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_REPORT));
    assign w_finish = (w_state_nxt == ST_REPORT);
    // In-flight data arriving after an early stop is dropped by the state gate.
    assign w_chk    = r_chk_vld && ((r_state == ST_SCAN) || (r_state == ST_DRAIN));

    // Bitmaps are cleared lazily: the first cell of a row / band sees an empty map.
    assign w_row_eff = (r_chk_col == '0) ? '0 : r_row_seen;
    assign w_blk_clr = (r_chk_col == '0) && (r_chk_rib == '0);
    assign w_blk_eff = w_blk_clr ? '0 : r_blk_seen[r_chk_bc];
    // Malformed cells are not recorded so they cannot trigger follow-on duplicates.
    assign w_add     = w_onehot ? bus.rd_data : '0;

    always_comb begin
        w_cell_kind = ERR_NONE;
        if (!w_onehot)                                     w_cell_kind = ERR_ENCODING;
        else if (|(bus.rd_data & w_row_eff))               w_cell_kind = ERR_ROW;
        else if (|(bus.rd_data & r_col_seen[r_chk_col]))   w_cell_kind = ERR_COL;
        else if (|(bus.rd_data & w_blk_eff))               w_cell_kind = ERR_BLOCK;
    end

    assign w_cell_err = w_chk && (w_cell_kind != ERR_NONE);

    // Result published on entry to REPORT; the current cell may be the first failure.
    assign w_fin_err  = r_err_found || w_cell_err;
    assign w_fin_kind = r_err_found ? r_first_kind : (w_cell_err ? w_cell_kind : ERR_NONE);
    assign w_fin_row  = r_err_found ? r_first_row  : (w_cell_err ? r_chk_row : '0);
    assign w_fin_col  = r_err_found ? r_first_col  : (w_cell_err ? r_chk_col : '0);

    // ---------------- datapath ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_addr    <= '0;
            r_chk_vld    <= 1'b0;
            r_chk_row    <= '0;
            r_chk_col    <= '0;
            r_chk_rib    <= '0;
            r_chk_cib    <= '0;
            r_chk_bc     <= '0;
            r_row_seen   <= '0;
            for (int i = 0; i < LENGTH; i++) r_col_seen[i] <= '0;
            for (int b = 0; b < ORDER; b++)  r_blk_seen[b] <= '0;
            r_err_found  <= 1'b0;
            r_first_kind <= ERR_NONE;
            r_first_row  <= '0;
            r_first_col  <= '0;
            r_pass       <= 1'b0;
            r_err_kind   <= ERR_NONE;
            r_err_row    <= '0;
            r_err_col    <= '0;
`ifdef GRID_CHECK_ERRCOUNT_EN
            r_err_cnt    <= '0;
            r_err_count  <= '0;
`endif
        end else begin
            r_chk_vld <= w_rd_en;
            if (w_accept) begin
                r_rd_addr    <= '0;
                r_chk_row    <= '0;
                r_chk_col    <= '0;
                r_chk_rib    <= '0;
                r_chk_cib    <= '0;
                r_chk_bc     <= '0;
                r_row_seen   <= '0;
                for (int i = 0; i < LENGTH; i++) r_col_seen[i] <= '0;
                for (int b = 0; b < ORDER; b++)  r_blk_seen[b] <= '0;
                r_err_found  <= 1'b0;
                r_first_kind <= ERR_NONE;
                r_first_row  <= '0;
                r_first_col  <= '0;
                r_pass       <= 1'b0;
                r_err_kind   <= ERR_NONE;
                r_err_row    <= '0;
                r_err_col    <= '0;
`ifdef GRID_CHECK_ERRCOUNT_EN
                r_err_cnt    <= '0;
                r_err_count  <= '0;
`endif
            end else begin
                // Address holds at the last cell (or the stop point) until the next start.
                if ((r_state == ST_SCAN) && (w_state_nxt == ST_SCAN))
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);

                if (w_chk) begin
                    if (r_chk_col == LAST_IDX) begin
                        r_chk_col <= '0;
                        r_chk_row <= r_chk_row + IDX_W'(1);
                        r_chk_cib <= '0;
                        r_chk_bc  <= '0;
                        r_chk_rib <= (r_chk_rib == LAST_BLK) ? '0 : r_chk_rib + BLK_W'(1);
                    end else begin
                        r_chk_col <= r_chk_col + IDX_W'(1);
                        if (r_chk_cib == LAST_BLK) begin
                            r_chk_cib <= '0;
                            r_chk_bc  <= r_chk_bc + BLK_W'(1);
                        end else begin
                            r_chk_cib <= r_chk_cib + BLK_W'(1);
                        end
                    end

                    r_row_seen            <= w_row_eff | w_add;
                    r_col_seen[r_chk_col] <= r_col_seen[r_chk_col] | w_add;
                    for (int b = 0; b < ORDER; b++)
                        r_blk_seen[b] <= (w_blk_clr ? '0 : r_blk_seen[b]) |
                                         ((BLK_W'(b) == r_chk_bc) ? w_add : '0);

                    if (w_cell_err && !r_err_found) begin
                        r_err_found  <= 1'b1;
                        r_first_kind <= w_cell_kind;
                        r_first_row  <= r_chk_row;
                        r_first_col  <= r_chk_col;
                    end
`ifdef GRID_CHECK_ERRCOUNT_EN
                    if (w_cell_err) r_err_cnt <= r_err_cnt + CNT_W'(1);
`endif
                end

                if (w_finish) begin
                    r_pass     <= !w_fin_err;
                    r_err_kind <= w_fin_kind;
                    r_err_row  <= w_fin_row;
                    r_err_col  <= w_fin_col;
`ifdef GRID_CHECK_ERRCOUNT_EN
                    r_err_count <= r_err_cnt + (w_cell_err ? CNT_W'(1) : CNT_W'(0));
`endif
                end
            end
        end
    end

    assign bus.rd_en    = w_rd_en;
    assign bus.rd_addr  = r_rd_addr;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.pass     = r_pass;
    assign bus.err_kind = r_err_kind;
    assign bus.err_row  = r_err_row;
    assign bus.err_col  = r_err_col;
`ifdef GRID_CHECK_ERRCOUNT_EN
    assign bus.err_count = r_err_count;
`endif

endmodule

// File: tb/tb_grid_checker.sv
// Self-checking bench for grid_checker: grid memory model, reference checker, per-cycle compare.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_grid_checker;
    import grid_check_pkg::*;

`ifdef GRID_CHECK_ERRCOUNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    grid_checker_if bus ();

    grid_checker dut (
        .i_clock (clk),
        .i_reset (reset),
        .bus     (bus.master)
    );

    // Grid storage: one-cycle read latency.
    value_t mem [AREA];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    int n_checks = 0;
    int n_errors = 0;
    int exp_kind, exp_row, exp_col, exp_cnt, exp_done, exp_last_rd;
    bit mon_active   = 1'b0;
    int mon_rel      = 0;
    int act_done_rel = -1;
    int n_rd         = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void fill_canon();
        for (int r = 0; r < LENGTH; r++)
            for (int c = 0; c < LENGTH; c++)
                mem[r*LENGTH + c] = value_t'(1) << ((r*ORDER + r/ORDER + c) % LENGTH);
    endfunction

    // Reference: each cell compared against every earlier cell by position arithmetic.
    function automatic void model();
        int first = -1;
        exp_cnt = 0;
        exp_kind = 0; exp_row = 0; exp_col = 0;
        for (int k = 0; k < AREA; k++) begin
            int r = k / LENGTH;
            int c = k % LENGTH;
            int kind = 0;
            if ($countones(mem[k]) != 1) kind = 1;
            else begin
                bit rd = 0, cd = 0, bd = 0;
                for (int j = 0; j < k; j++) begin
                    if (mem[j] == mem[k]) begin
                        if (j / LENGTH == r) rd = 1;
                        if (j % LENGTH == c) cd = 1;
                        if ((j / LENGTH) / ORDER == r / ORDER && (j % LENGTH) / ORDER == c / ORDER) bd = 1;
                    end
                end
                kind = rd ? 2 : cd ? 3 : bd ? 4 : 0;
            end
            if (kind != 0) begin
                exp_cnt++;
                if (first < 0) begin
                    first = k; exp_kind = kind; exp_row = r; exp_col = c;
                end
            end
        end
        if (first < 0 || ERRCNT) begin
            exp_done    = AREA + 2;
            exp_last_rd = AREA;
        end else begin
            exp_done    = first + 3;
            exp_last_rd = (first + 2 < AREA) ? first + 2 : AREA;
        end
    endfunction

    // Compare process: every cycle of a scan, DUT against the reference.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_active) begin
                mon_rel++;
                if (bus.rd_en) n_rd++;
                if (bus.done && act_done_rel < 0) act_done_rel = mon_rel;
                chk("busy", int'(bus.busy), int'(mon_rel < exp_done));
                chk("rd_en", int'(bus.rd_en), int'(mon_rel <= exp_last_rd));
                if (bus.rd_en) chk("rd_addr", int'(bus.rd_addr), mon_rel - 1);
                chk("done", int'(bus.done), int'(mon_rel == exp_done));
                if (mon_rel == exp_done) begin
                    chk("pass", int'(bus.pass), int'(exp_kind == 0));
                    chk("err_kind", int'(bus.err_kind), exp_kind);
                    chk("err_row", int'(bus.err_row), exp_row);
                    chk("err_col", int'(bus.err_col), exp_col);
`ifdef GRID_CHECK_ERRCOUNT_EN
                    chk("err_count", int'(bus.err_count), exp_cnt);
`endif
                    mon_active = 1'b0;
                end
            end
        end
    endtask

    // Start is already high; the coming edge is cycle 0 of the scan.
    task automatic begin_mon();
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        mon_rel      = 0;
        act_done_rel = -1;
        n_rd         = 0;
        mon_active   = 1'b1;
    endtask

    // mode 0 plain, 1 stray starts at cycles 10/50, 2 reset at cycle 40, 3 restart in REPORT
    task automatic run_scan(input int mode);
        int guard = 0;
        model();
        @(negedge clk);
        bus.start = 1'b1;
        begin_mon();
        while (mon_active && guard < 400) begin
            @(negedge clk);
            #1;
            guard++;
            bus.start = (mode == 1) && (mon_rel == 10 || mon_rel == 50);
            if (mode == 3 && mon_rel == exp_done) begin
                bus.start = 1'b1;
                mode = 0;
                begin_mon();
            end else if (mode == 2 && mon_rel == 40) begin
                bit seen = 1'b0;
                reset = 1'b1;
                mon_active = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                chk("rst_busy", int'(bus.busy), 0);
                chk("rst_rd_en", int'(bus.rd_en), 0);
                repeat (100) begin
                    @(negedge clk);
                    if (bus.done) seen = 1'b1;
                end
                chk("rst_no_done", int'(seen), 0);
                chk("rst_pass", int'(bus.pass), 0);
            end
        end
        if (mon_active) begin
            n_checks++;
            n_errors++;
            $display("FAIL scan_timeout: scan still active after %0d cycles, expected done at %0d", guard, exp_done);
            mon_active = 1'b0;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        fill_canon();
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_rd_en", int'(bus.rd_en), 0);
        chk("reset_rd_addr", int'(bus.rd_addr), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_pass", int'(bus.pass), 0);
        chk("reset_err_kind", int'(bus.err_kind), 0);
        chk("reset_err_row", int'(bus.err_row), 0);
        chk("reset_err_col", int'(bus.err_col), 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: canonical grid passes
        fill_canon();
        run_scan(0);
        chk("t1_done_cycle", act_done_rel, 83);
        chk("t1_rd_cycles", n_rd, 81);
        chk("t1_pass", int'(bus.pass), 1);
        repeat (3) @(negedge clk);
        chk("t1_hold_pass", int'(bus.pass), 1);
        chk("t1_hold_done", int'(bus.done), 0);

        // 2: row duplicate at (4,7)
        fill_canon();
        mem[4*9+7] = mem[4*9+2];
        run_scan(0);
        chk("t2_kind", int'(bus.err_kind), 2);
        chk("t2_row", int'(bus.err_row), 4);
        chk("t2_col", int'(bus.err_col), 7);
        chk("t2_done_cycle", act_done_rel, ERRCNT ? 83 : 46);
        chk("t2_rd_cycles", n_rd, ERRCNT ? 81 : 45);
        repeat (3) @(negedge clk);
        chk("t2_hold_kind", int'(bus.err_kind), 2);
        chk("t2_hold_pass", int'(bus.pass), 0);

        // 3: encoding errors at (2,5)
        fill_canon();
        mem[2*9+5] = 9'h000;
        run_scan(0);
        chk("t3a_kind", int'(bus.err_kind), 1);
        chk("t3a_loc", int'(bus.err_row) * 16 + int'(bus.err_col), 2*16 + 5);
        chk("t3a_done_cycle", act_done_rel, ERRCNT ? 83 : 26);
        fill_canon();
        mem[2*9+5] = 9'h003;
        run_scan(0);
        chk("t3b_kind", int'(bus.err_kind), 1);
        chk("t3b_loc", int'(bus.err_row) * 16 + int'(bus.err_col), 2*16 + 5);

        // 4: block-only duplicate at (1,1), column-only duplicate at (8,3)
        fill_canon();
        mem[1*9+1] = mem[0];
        run_scan(0);
        chk("t4a_kind", int'(bus.err_kind), 4);
        chk("t4a_loc", int'(bus.err_row) * 16 + int'(bus.err_col), 1*16 + 1);
        chk("t4a_done_cycle", act_done_rel, ERRCNT ? 83 : 13);
        fill_canon();
        mem[8*9+3] = 9'h008;
        run_scan(0);
        chk("t4b_kind", int'(bus.err_kind), 3);
        chk("t4b_loc", int'(bus.err_row) * 16 + int'(bus.err_col), 8*16 + 3);
        chk("t4b_done_cycle", act_done_rel, ERRCNT ? 83 : 78);

        // 5: reset mid-scan, then clean rescan
        fill_canon();
        run_scan(2);
        run_scan(0);
        chk("t5_done_cycle", act_done_rel, 83);
        chk("t5_pass", int'(bus.pass), 1);

        // 6: stray starts ignored; start in REPORT chains a new scan
        run_scan(1);
        chk("t6a_done_cycle", act_done_rel, 83);
        chk("t6a_pass", int'(bus.pass), 1);
        run_scan(3);
        chk("t6b_done_cycle", act_done_rel, 83);
        chk("t6b_pass", int'(bus.pass), 1);

`ifdef GRID_CHECK_ERRCOUNT_EN
        // Counting build: two bad cells, first location reported
        fill_canon();
        mem[0*9+1] = 9'h000;
        mem[7*9+7] = 9'h000;
        run_scan(0);
        chk("ec_done_cycle", act_done_rel, 83);
        chk("ec_count", int'(bus.err_count), 2);
        chk("ec_kind", int'(bus.err_kind), 1);
        chk("ec_loc", int'(bus.err_row) * 16 + int'(bus.err_col), 0*16 + 1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
